// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    CLEAR,
    SERVE
  } arb_state_t;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 64;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/regfile_load_decoder.sv
// One-hot decode of the registered write address into per-register load strobes.
module regfile_load_decoder
  import regfile_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  localparam int unsigned DEPTH  = depth_of(ADDR_W)
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [DEPTH-1:0]  wr_load
);

  always_comb begin
    wr_load = '0;
    if (wr_en) wr_load[wr_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter with post-reset / on-demand zero-fill sweep.
// Optional: REGARB_ZERO_GUARD_EN suppresses requester writes to address 0.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = DEF_N_REQ,
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned DEPTH  = depth_of(ADDR_W)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       clear_req,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [DEPTH-1:0]           wr_load,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_t        state, state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [PTR_W-1:0]  rr_ptr, grant_idx, ptr_next;
  logic              grant_any, write_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_cnt == '1) state_next = SERVE;
      SERVE:   if (clear_req)       state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // First valid requester at or above the pointer, wrapping; clear_req blocks all grants.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    if (state == SERVE && !clear_req) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx  = (32'(rr_ptr) + k) % N_REQ;
        cand = idx[PTR_W-1:0];
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
          sel_addr  = addr_arr[cand];
          sel_data  = data_arr[cand];
        end
      end
    end
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_next = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
`ifdef REGARB_ZERO_GUARD_EN
    write_ok = grant_any && (sel_addr != '0);
`else
    write_ok = grant_any;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sweep_cnt <= '0;
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          wr_en     <= 1'b1;
          wr_addr   <= sweep_cnt;
          wr_data   <= '0;
          sweep_cnt <= sweep_cnt + ADDR_W'(1);
          if (sweep_cnt == '1) busy <= 1'b0;
        end
        SERVE: begin
          if (clear_req) begin
            wr_en     <= 1'b0;
            sweep_cnt <= '0;
            busy      <= 1'b1;
          end else if (grant_any) begin
            wr_en   <= write_ok;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            rr_ptr  <= ptr_next;
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

  regfile_load_decoder #(
    .ADDR_W(ADDR_W)
  ) u_load_decoder (
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_load(wr_load)
  );

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin write-port arbiter and sequencer for the register file built from `register` instances. It shares the file's single write port among `N_REQ` requesters using a valid/ready handshake. It drives the per-register `load` strobes through a one-hot decode. It also runs a zero-fill sweep of the whole file after reset and on demand.

## Interface
- `N_REQ`, 4: number of requesters (≥2)
- `ADDR_W`, 5: register address width; file depth `DEPTH = 2**ADDR_W`
- `DATA_W`, 64: register data width
- `clock` input 1: single clock, all logic on rising edge
- `reset` input 1: one clock; reset is synchronous and active-low
- `req_valid` input `N_REQ`: per-requester write request
- `req_addr` input `N_REQ*ADDR_W`: flattened addresses, requester i at bits `[i*ADDR_W +: ADDR_W]`
- `req_data` input `N_REQ*DATA_W`: flattened data, requester i at bits `[i*DATA_W +: DATA_W]`
- `req_ready` output `N_REQ`: grant; at most one bit high per cycle
- `clear_req` input 1: request a full zero-fill sweep
- `wr_en` output 1: registered write strobe
- `wr_addr` output `ADDR_W`: registered write address
- `wr_data` output `DATA_W`: registered write data, drives every register's `data_in`
- `wr_load` output `DEPTH`: one-hot `load` strobes, equal to decode(`wr_addr`) gated by `wr_en`
- `busy` output 1: high while the sweep is in progress

## Operation
- FSM states: CLEAR, SERVE.
- Reset (`reset`=0 at an edge): state=CLEAR, sweep counter=0, RR pointer=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_load`=0, `busy`=1.
- CLEAR:
  - `req_ready`=0.
  - Each cycle registers `wr_en`=1, `wr_addr`=counter, `wr_data`=0, then counter+1.
  - When counter=`DEPTH-1` is issued, go to SERVE and clear `busy`.
  - `clear_req` is ignored in CLEAR.
- SERVE:
  - Round-robin over `req_valid`, starting at the RR pointer and searching upward with wrap.
  - The winner i gets `req_ready[i]`=1 combinationally in the same cycle. A transfer occurs when valid&ready are both high.
  - After the transfer, the pointer becomes (i+1) mod `N_REQ`. The pointer does not change in cycles with no grant.
  - Next edge: `wr_en`=1, `wr_addr`/`wr_data` = the winner's address and data.
  - No valid requests: `wr_en`=0; `wr_addr`/`wr_data` hold their values.
- `clear_req`=1 in SERVE:
  - No grant that cycle.
  - Next state CLEAR, counter=0, `busy`=1 at the next edge.
  - `clear_req` wins over any simultaneous `req_valid`.
- The write port always accepts, so no backpressure exists beyond arbitration.
- Requesters hold valid, address and data stable until they see ready.
- Two requesters addressing the same register in consecutive cycles produce two writes, in grant order.

## Timing
- Request-to-write latency: 1 cycle. `wr_load` is valid in the cycle after the grant, and the register captures the data on the following edge.
- Sustained throughput: one write per cycle.
- A sweep takes exactly `DEPTH` cycles with `wr_en` high. The first grant is possible in the cycle after the last sweep write.
- Reset asserted mid-sweep or mid-stream: the sweep restarts from address 0, and any in-flight output write is dropped (`wr_en`=0).
- `wr_load` is zero whenever `wr_en`=0.

## Configuration
- `REGARB_ZERO_GUARD_EN` defined:
  - Address 0 is hardwired zero.
  - Granted requests to address 0 still complete the handshake (ready=1), but the next-cycle `wr_en`=0 and `wr_load`=0.
  - The pointer still advances.
  - The sweep still writes 0 to address 0.
- `REGARB_ZERO_GUARD_EN` undefined: address 0 is written like any other address.

## Structure
- Package `regfile_arb_pkg`:
  - State enum {CLEAR, SERVE}.
  - Default constants for `N_REQ`, `ADDR_W`, `DATA_W`.
  - `DEPTH` derivation helper.
- One sub-module, `regfile_load_decoder`. It is parameterised by `ADDR_W` and maps `wr_en` and `wr_addr` to `wr_load`.
- The RR search, pointer, counter and FSM stay in the top module.

## Test plan
- Reset release, `ADDR_W`=5 → `busy`=1 for 32 cycles; `wr_addr` goes 0..31 with `wr_data`=0 and one-hot `wr_load`; `req_ready`=0 throughout; `busy`=0 afterwards.
- In SERVE, `req_valid`=4'b1111 held for 8 cycles with pointer=0 → grants 0,1,2,3,0,1,2,3; each `wr_addr`/`wr_data` matches the winner one cycle later.
- `req_valid`=4'b0100 alone, address 7, data 64'hDEAD_BEEF → `req_ready`=4'b0100 the same cycle; next cycle `wr_en`=1, `wr_load`=1<<7.
- `clear_req` and `req_valid`=4'b0011 in the same cycle → `req_ready`=0; a 32-cycle sweep follows; requester 0 is granted first after the sweep.
- Reset asserted during sweep cycle 10 → next edge `wr_en`=0; after release, the sweep restarts at address 0.
- With `REGARB_ZERO_GUARD_EN` defined, requester 2 writes address 0 → ready=1, `wr_en`=0 next cycle, and the pointer moves to 3.
